// File: rtl/tb_pzcorebus_bfm_pkg.sv
// Shared corebus types for the master-side BFM helpers: bus configuration,
// command/response encodings, the non-posted classifier and the ID table entry.
package tb_pzcorebus_bfm_pkg;

   typedef struct packed {
      logic [7:0] id_width;
      logic [7:0] address_width;
      logic [7:0] data_width;
      logic [7:0] length_width;
   } pzcorebus_config;

   localparam int DEFAULT_ID_WIDTH      = 8;
   localparam int DEFAULT_ADDRESS_WIDTH = 32;
   localparam int DEFAULT_DATA_WIDTH    = 32;
   localparam int DEFAULT_LENGTH_WIDTH  = 8;
   localparam int ID_WIDTH_MAX          = 16;

   typedef enum logic [3:0] {
      PZCOREBUS_NULL                  = 4'd0,
      PZCOREBUS_READ                  = 4'd1,
      PZCOREBUS_WRITE                 = 4'd2,
      PZCOREBUS_WRITE_NON_POSTED      = 4'd3,
      PZCOREBUS_FULL_WRITE            = 4'd4,
      PZCOREBUS_FULL_WRITE_NON_POSTED = 4'd5,
      PZCOREBUS_BROADCAST             = 4'd6,
      PZCOREBUS_ATOMIC                = 4'd7,
      PZCOREBUS_MESSAGE               = 4'd8,
      PZCOREBUS_MESSAGE_NON_POSTED    = 4'd9
   } pzcorebus_command_type;

   typedef enum logic [1:0] {
      PZCOREBUS_NULL_RESPONSE      = 2'd0,
      PZCOREBUS_RESPONSE           = 2'd1,
      PZCOREBUS_RESPONSE_WITH_DATA = 2'd2
   } pzcorebus_response_type;

   // IDs are stored zero-extended so one entry type serves every bus width
   typedef struct packed {
      logic                    valid;
      logic [ID_WIDTH_MAX-1:0] id;
   } np_id_entry_t;

   function automatic int pick_width(logic [7:0] cfg_width, int default_width);
      int width;
      if (cfg_width == 8'd0) begin
         width = default_width;
      end else begin
         width = int'(cfg_width);
      end
      return width;
   endfunction

   function automatic int get_id_width(pzcorebus_config cfg);
      return pick_width(cfg.id_width, DEFAULT_ID_WIDTH);
   endfunction

   function automatic logic is_non_posted(pzcorebus_command_type cmd);
      logic np;
      case (cmd)
         PZCOREBUS_READ,
         PZCOREBUS_WRITE_NON_POSTED,
         PZCOREBUS_FULL_WRITE_NON_POSTED,
         PZCOREBUS_ATOMIC,
         PZCOREBUS_MESSAGE_NON_POSTED: np = 1'b1;
         default:                      np = 1'b0;
      endcase
      return np;
   endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// Corebus point-to-point link: command, write-data and response channels.
interface pzcorebus_if
   import tb_pzcorebus_bfm_pkg::*;
#(
   parameter pzcorebus_config BUS_CONFIG = '0
);
   localparam int ID_WIDTH      = get_id_width(BUS_CONFIG);
   localparam int ADDRESS_WIDTH = pick_width(BUS_CONFIG.address_width, DEFAULT_ADDRESS_WIDTH);
   localparam int DATA_WIDTH    = pick_width(BUS_CONFIG.data_width, DEFAULT_DATA_WIDTH);
   localparam int LENGTH_WIDTH  = pick_width(BUS_CONFIG.length_width, DEFAULT_LENGTH_WIDTH);

   logic                   mcmd_valid;
   logic                   scmd_accept;
   pzcorebus_command_type  mcmd;
   logic [ID_WIDTH-1:0]    mid;
   logic [ADDRESS_WIDTH-1:0] maddress;
   logic [LENGTH_WIDTH-1:0]  mlength;

   logic                   mdata_valid;
   logic                   sdata_accept;
   logic [DATA_WIDTH-1:0]  mdata;
   logic                   mdata_last;

   logic                   sresp_valid;
   logic                   mresp_accept;
   pzcorebus_response_type sresp;
   logic [ID_WIDTH-1:0]    sid;
   logic                   serror;
   logic [DATA_WIDTH-1:0]  sdata;
   logic                   sresp_last;

   modport master (
      output mcmd_valid, mcmd, mid, maddress, mlength,
      output mdata_valid, mdata, mdata_last,
      output mresp_accept,
      input  scmd_accept, sdata_accept,
      input  sresp_valid, sresp, sid, serror, sdata, sresp_last
   );

   modport slave (
      input  mcmd_valid, mcmd, mid, maddress, mlength,
      input  mdata_valid, mdata, mdata_last,
      input  mresp_accept,
      output scmd_accept, sdata_accept,
      output sresp_valid, sresp, sid, serror, sdata, sresp_last
   );

endinterface

// File: rtl/tb_pzcorebus_np_id_table.sv
// Outstanding non-posted ID table: lookup, lowest-free allocation, release by
// response ID, registered occupancy/full and an unmatched-release pulse.
module tb_pzcorebus_np_id_table
   import tb_pzcorebus_bfm_pkg::*;
#(
   parameter int ENTRIES     = 8,
   parameter int ID_WIDTH    = 8,
   parameter int COUNT_WIDTH = $clog2(ENTRIES + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ID_WIDTH-1:0]    lookup_id_i,
   output logic                   hit_o,
   input  logic                   alloc_i,
   input  logic [ID_WIDTH-1:0]    alloc_id_i,
   input  logic                   release_i,
   input  logic [ID_WIDTH-1:0]    release_id_i,
   output logic [COUNT_WIDTH-1:0] count_o,
   output logic                   full_o,
   output logic                   unexpected_o
);
   np_id_entry_t entry_q [ENTRIES];
   np_id_entry_t entry_d [ENTRIES];

   logic [COUNT_WIDTH-1:0]  count_q, count_d;
   logic                    full_q, full_d;
   logic                    unexpected_q, unexpected_d;

   logic [ID_WIDTH_MAX-1:0] lookup_ext_s, alloc_ext_s, release_ext_s;
   logic [ENTRIES-1:0]      hit_vec_s, rel_vec_s, free_vec_s, free_first_s;
   logic                    alloc_ok_s, rel_ok_s;

   // Per-entry compares and lowest-free one-hot select
   always_comb begin
      lookup_ext_s  = ID_WIDTH_MAX'(lookup_id_i);
      alloc_ext_s   = ID_WIDTH_MAX'(alloc_id_i);
      release_ext_s = ID_WIDTH_MAX'(release_id_i);
      hit_vec_s     = '0;
      rel_vec_s     = '0;
      free_vec_s    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hit_vec_s[i]  = entry_q[i].valid && (entry_q[i].id == lookup_ext_s);
         rel_vec_s[i]  = entry_q[i].valid && (entry_q[i].id == release_ext_s);
         free_vec_s[i] = !entry_q[i].valid;
      end
      free_first_s = free_vec_s & (~free_vec_s + ENTRIES'(1'b1));
   end

   // Next table contents; release and allocate never touch the same slot
   always_comb begin
      entry_d      = entry_q;
      alloc_ok_s   = alloc_i && (|free_vec_s);
      rel_ok_s     = release_i && (|rel_vec_s);
      for (int i = 0; i < ENTRIES; i++) begin
         if (rel_ok_s && rel_vec_s[i]) begin
            entry_d[i].valid = 1'b0;
         end else if (alloc_ok_s && free_first_s[i]) begin
            entry_d[i].valid = 1'b1;
            entry_d[i].id    = alloc_ext_s;
         end else begin
            entry_d[i] = entry_q[i];
         end
      end
      count_d      = count_q + COUNT_WIDTH'(alloc_ok_s) - COUNT_WIDTH'(rel_ok_s);
      full_d       = (count_d == COUNT_WIDTH'(ENTRIES));
      unexpected_d = release_i && !(|rel_vec_s);
   end

   // Table and status registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_q[i] <= '0;
         end
         count_q      <= '0;
         full_q       <= 1'b0;
         unexpected_q <= 1'b0;
      end else begin
         entry_q      <= entry_d;
         count_q      <= count_d;
         full_q       <= full_d;
         unexpected_q <= unexpected_d;
      end
   end

   assign hit_o        = |hit_vec_s;
   assign count_o      = count_q;
   assign full_o       = full_q;
   assign unexpected_o = unexpected_q;

endmodule

// File: rtl/tb_pzcorebus_np_id_lock_ctrl.sv
// Holds back non-posted commands whose ID is already in flight or that arrive
// while the ID table is full; data and responses pass straight through.
module tb_pzcorebus_np_id_lock_ctrl
   import tb_pzcorebus_bfm_pkg::*;
#(
   parameter pzcorebus_config BUS_CONFIG  = '0,
   parameter int              ENTRIES     = 8,
   parameter int              COUNT_WIDTH = $clog2(ENTRIES + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   pzcorebus_if.slave             slave_if,
   pzcorebus_if.master            master_if,
   output logic [COUNT_WIDTH-1:0] o_outstanding,
   output logic                   o_full,
   output logic                   o_id_stall,
   output logic [31:0]            o_stall_cycles,
   output logic                   o_unexpected_resp
);
   localparam int ID_WIDTH = get_id_width(BUS_CONFIG);

   logic        np_cmd_s, hit_s, full_s, block_s, fwd_valid_s, alloc_s, release_s;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   tb_pzcorebus_np_id_table #(
      .ENTRIES     (ENTRIES),
      .ID_WIDTH    (ID_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_table (
      .clk_i        (i_clk),
      .rst_i        (i_rst),
      .lookup_id_i  (slave_if.mid),
      .hit_o        (hit_s),
      .alloc_i      (alloc_s),
      .alloc_id_i   (slave_if.mid),
      .release_i    (release_s),
      .release_id_i (master_if.sid),
      .count_o      (o_outstanding),
      .full_o       (full_s),
      .unexpected_o (o_unexpected_resp)
   );

   // Gating looks only at the registered table and upstream valid/fields,
   // so a same-cycle release never bypasses into the command decision.
   always_comb begin
      np_cmd_s    = is_non_posted(slave_if.mcmd);
      block_s     = slave_if.mcmd_valid && np_cmd_s && (hit_s || full_s);
      fwd_valid_s = slave_if.mcmd_valid && !block_s;
      alloc_s     = fwd_valid_s && master_if.scmd_accept && np_cmd_s;
      release_s   = master_if.sresp_valid && slave_if.mresp_accept && master_if.sresp_last;
   end

   // Saturating stall-cycle counter
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (block_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // Stall counter register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign o_full         = full_s;
   assign o_id_stall     = block_s;
   assign o_stall_cycles = stall_cycles_q;

   assign master_if.mcmd_valid   = fwd_valid_s;
   assign slave_if.scmd_accept   = master_if.scmd_accept && !block_s;
   assign master_if.mcmd         = slave_if.mcmd;
   assign master_if.mid          = slave_if.mid;
   assign master_if.maddress     = slave_if.maddress;
   assign master_if.mlength      = slave_if.mlength;

   assign master_if.mdata_valid  = slave_if.mdata_valid;
   assign master_if.mdata        = slave_if.mdata;
   assign master_if.mdata_last   = slave_if.mdata_last;
   assign slave_if.sdata_accept  = master_if.sdata_accept;

   assign slave_if.sresp_valid   = master_if.sresp_valid;
   assign slave_if.sresp         = master_if.sresp;
   assign slave_if.sid           = master_if.sid;
   assign slave_if.serror        = master_if.serror;
   assign slave_if.sdata         = master_if.sdata;
   assign slave_if.sresp_last    = master_if.sresp_last;
   assign master_if.mresp_accept = slave_if.mresp_accept;

endmodule

// File: tb/tb_tb_pzcorebus_np_id_lock_ctrl.sv
// Directed bench for the non-posted ID lock controller.
module tb_tb_pzcorebus_np_id_lock_ctrl;
   import tb_pzcorebus_bfm_pkg::*;

   logic        i_clk;
   logic        i_rst;
   logic [3:0]  outstanding_s;
   logic        full_s;
   logic        id_stall_s;
   logic [31:0] stall_cycles_s;
   logic        unexpected_s;

   int n_checks;
   int n_fail;

   pzcorebus_if up_if ();
   pzcorebus_if dn_if ();

   tb_pzcorebus_np_id_lock_ctrl dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .slave_if          (up_if),
      .master_if         (dn_if),
      .o_outstanding     (outstanding_s),
      .o_full            (full_s),
      .o_id_stall        (id_stall_s),
      .o_stall_cycles    (stall_cycles_s),
      .o_unexpected_resp (unexpected_s)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are read here
   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   task automatic drive_cmd(input pzcorebus_command_type c, input logic [7:0] id);
      up_if.mcmd_valid = 1'b1;
      up_if.mcmd       = c;
      up_if.mid        = id;
      up_if.maddress   = {24'h000100, id};
      up_if.mlength    = 8'd3;
   endtask

   task automatic drop_cmd();
      up_if.mcmd_valid = 1'b0;
      up_if.mcmd       = PZCOREBUS_NULL;
   endtask

   task automatic drive_resp(input logic [7:0] id, input logic last);
      dn_if.sresp_valid = 1'b1;
      dn_if.sresp       = PZCOREBUS_RESPONSE_WITH_DATA;
      dn_if.sid         = id;
      dn_if.sresp_last  = last;
      dn_if.sdata       = {24'hA5A5A5, id};
   endtask

   task automatic drop_resp();
      dn_if.sresp_valid = 1'b0;
      dn_if.sresp_last  = 1'b0;
   endtask

   // Issue one command that must pass without stall, then idle the channel
   task automatic accept_cmd(input string tag, input pzcorebus_command_type c, input logic [7:0] id);
      drive_cmd(c, id);
      #1;
      check_eq({tag, "_fwd_valid"}, 32'(dn_if.mcmd_valid), 32'd1);
      check_eq({tag, "_up_accept"}, 32'(up_if.scmd_accept), 32'd1);
      step();
      drop_cmd();
   endtask

   task automatic release_id(input logic [7:0] id);
      drive_resp(id, 1'b1);
      step();
      drop_resp();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      i_rst    = 1'b1;
      up_if.mcmd_valid   = 1'b0;
      up_if.mcmd         = PZCOREBUS_NULL;
      up_if.mid          = 8'd0;
      up_if.maddress     = 32'd0;
      up_if.mlength      = 8'd0;
      up_if.mdata_valid  = 1'b0;
      up_if.mdata        = 32'd0;
      up_if.mdata_last   = 1'b0;
      up_if.mresp_accept = 1'b1;
      dn_if.scmd_accept  = 1'b1;
      dn_if.sdata_accept = 1'b1;
      dn_if.sresp_valid  = 1'b0;
      dn_if.sresp        = PZCOREBUS_NULL_RESPONSE;
      dn_if.sid          = 8'd0;
      dn_if.serror       = 1'b0;
      dn_if.sdata        = 32'd0;
      dn_if.sresp_last   = 1'b0;

      #12;
      check_eq("rst_outstanding", 32'(outstanding_s), 32'd0);
      check_eq("rst_full", 32'(full_s), 32'd0);
      check_eq("rst_stall_cycles", stall_cycles_s, 32'd0);
      check_eq("rst_unexpected", 32'(unexpected_s), 32'd0);
      i_rst = 1'b0;
      step();

      // Back-to-back READs id 3 and 4
      drive_cmd(PZCOREBUS_READ, 8'd3);
      #1;
      check_eq("t1_fwd_valid", 32'(dn_if.mcmd_valid), 32'd1);
      check_eq("t1_stall", 32'(id_stall_s), 32'd0);
      check_eq("t1_mid_pass", 32'(dn_if.mid), 32'd3);
      step();
      check_eq("t1_out1", 32'(outstanding_s), 32'd1);
      accept_cmd("t1_rd4", PZCOREBUS_READ, 8'd4);
      check_eq("t1_out2", 32'(outstanding_s), 32'd2);

      // Downstream refusal allocates nothing
      dn_if.scmd_accept = 1'b0;
      drive_cmd(PZCOREBUS_READ, 8'd9);
      #1;
      check_eq("t1_noacc_up", 32'(up_if.scmd_accept), 32'd0);
      check_eq("t1_noacc_stall", 32'(id_stall_s), 32'd0);
      step();
      drop_cmd();
      dn_if.scmd_accept = 1'b1;
      check_eq("t1_noacc_out", 32'(outstanding_s), 32'd2);

      // Duplicate id 5 is held until one cycle after its last response
      accept_cmd("t2_rd5", PZCOREBUS_READ, 8'd5);
      check_eq("t2_out3", 32'(outstanding_s), 32'd3);
      drive_cmd(PZCOREBUS_READ, 8'd5);
      #1;
      check_eq("t2_stall", 32'(id_stall_s), 32'd1);
      check_eq("t2_fwd_blocked", 32'(dn_if.mcmd_valid), 32'd0);
      check_eq("t2_up_blocked", 32'(up_if.scmd_accept), 32'd0);
      step();
      check_eq("t2_stall_cnt1", stall_cycles_s, 32'd1);
      step();
      check_eq("t2_stall_cnt2", stall_cycles_s, 32'd2);
      drive_resp(8'd5, 1'b1);
      #1;
      check_eq("t2_no_bypass", 32'(id_stall_s), 32'd1);
      check_eq("t2_resp_pass", 32'(up_if.sresp_valid), 32'd1);
      check_eq("t2_sid_pass", 32'(up_if.sid), 32'd5);
      step();
      drop_resp();
      check_eq("t2_stall_cnt3", stall_cycles_s, 32'd3);
      check_eq("t2_out_rel", 32'(outstanding_s), 32'd2);
      #1;
      check_eq("t2_now_accepted", 32'(dn_if.mcmd_valid), 32'd1);
      check_eq("t2_stall_clear", 32'(id_stall_s), 32'd0);
      step();
      drop_cmd();
      check_eq("t2_out_realloc", 32'(outstanding_s), 32'd3);
      check_eq("t2_stall_final", stall_cycles_s, 32'd3);

      // Fill to 8 with ids 10..14
      for (int i = 10; i < 15; i++) begin
         accept_cmd("t3_fill", PZCOREBUS_READ, 8'(i));
      end
      check_eq("t3_out8", 32'(outstanding_s), 32'd8);
      check_eq("t3_full", 32'(full_s), 32'd1);
      drive_cmd(PZCOREBUS_READ, 8'd20);
      #1;
      check_eq("t3_full_stall", 32'(id_stall_s), 32'd1);
      check_eq("t3_full_fwd", 32'(dn_if.mcmd_valid), 32'd0);
      step();
      drive_cmd(PZCOREBUS_WRITE, 8'd0);
      up_if.mdata_valid  = 1'b1;
      up_if.mdata        = 32'hDEAD_BEEF;
      up_if.mdata_last   = 1'b1;
      dn_if.sdata_accept = 1'b0;
      #1;
      check_eq("t3_posted_fwd", 32'(dn_if.mcmd_valid), 32'd1);
      check_eq("t3_posted_acc", 32'(up_if.scmd_accept), 32'd1);
      check_eq("t3_posted_stall", 32'(id_stall_s), 32'd0);
      check_eq("t3_mcmd_pass", 32'(dn_if.mcmd), 32'(PZCOREBUS_WRITE));
      check_eq("t3_mdata_pass", dn_if.mdata, 32'hDEAD_BEEF);
      check_eq("t3_sdata_acc_pass", 32'(up_if.sdata_accept), 32'd0);
      step();
      up_if.mdata_valid  = 1'b0;
      up_if.mdata_last   = 1'b0;
      dn_if.sdata_accept = 1'b1;
      check_eq("t3_posted_out", 32'(outstanding_s), 32'd8);
      drive_cmd(PZCOREBUS_WRITE_NON_POSTED, 8'd21);
      #1;
      check_eq("t3_wnp_stall", 32'(id_stall_s), 32'd1);
      step();
      drive_cmd(PZCOREBUS_READ, 8'd20);
      drive_resp(8'd10, 1'b1);
      #1;
      check_eq("t3_full_rel_block", 32'(id_stall_s), 32'd1);
      step();
      drop_resp();
      check_eq("t3_out7", 32'(outstanding_s), 32'd7);
      check_eq("t3_not_full", 32'(full_s), 32'd0);
      check_eq("t3_stall_cnt", stall_cycles_s, 32'd6);
      #1;
      check_eq("t3_rd20_fwd", 32'(dn_if.mcmd_valid), 32'd1);
      step();
      drop_cmd();
      check_eq("t3_refull_out", 32'(outstanding_s), 32'd8);
      check_eq("t3_refull", 32'(full_s), 32'd1);

      // Multi-beat response for id 2: only the accepted last beat releases
      release_id(8'd11);
      release_id(8'd12);
      check_eq("t4_out6", 32'(outstanding_s), 32'd6);
      accept_cmd("t4_rd2", PZCOREBUS_READ, 8'd2);
      check_eq("t4_out7", 32'(outstanding_s), 32'd7);
      for (int b = 0; b < 3; b++) begin
         drive_resp(8'd2, 1'b0);
         step();
         check_eq("t4_beat_hold", 32'(outstanding_s), 32'd7);
      end
      drive_resp(8'd2, 1'b1);
      up_if.mresp_accept = 1'b0;
      #1;
      check_eq("t4_macc_pass", 32'(dn_if.mresp_accept), 32'd0);
      step();
      check_eq("t4_last_noacc", 32'(outstanding_s), 32'd7);
      up_if.mresp_accept = 1'b1;
      #1;
      check_eq("t4_last_pending", 32'(outstanding_s), 32'd7);
      step();
      drop_resp();
      check_eq("t4_last_rel", 32'(outstanding_s), 32'd6);

      // Response for an ID nobody holds
      drive_resp(8'd7, 1'b1);
      #1;
      check_eq("t5_unexp_early", 32'(unexpected_s), 32'd0);
      step();
      drop_resp();
      check_eq("t5_unexp_pulse", 32'(unexpected_s), 32'd1);
      check_eq("t5_out_same", 32'(outstanding_s), 32'd6);
      step();
      check_eq("t5_unexp_drop", 32'(unexpected_s), 32'd0);

      // Allocate 30 while releasing 3 in the same cycle
      drive_cmd(PZCOREBUS_READ, 8'd30);
      drive_resp(8'd3, 1'b1);
      #1;
      check_eq("t5_swap_fwd", 32'(dn_if.mcmd_valid), 32'd1);
      step();
      drop_cmd();
      drop_resp();
      check_eq("t5_swap_out", 32'(outstanding_s), 32'd6);
      check_eq("t5_swap_unexp", 32'(unexpected_s), 32'd0);
      drive_cmd(PZCOREBUS_READ, 8'd3);
      #1;
      check_eq("t5_id3_free", 32'(id_stall_s), 32'd0);
      drive_cmd(PZCOREBUS_ATOMIC, 8'd30);
      #1;
      check_eq("t5_id30_held", 32'(id_stall_s), 32'd1);
      drop_cmd();
      #1;

      // Asynchronous reset with three IDs in flight
      release_id(8'd13);
      release_id(8'd14);
      release_id(8'd30);
      check_eq("t6_out3", 32'(outstanding_s), 32'd3);
      #2;
      i_rst = 1'b1;
      #1;
      check_eq("t6_rst_out", 32'(outstanding_s), 32'd0);
      check_eq("t6_rst_full", 32'(full_s), 32'd0);
      check_eq("t6_rst_stall_cnt", stall_cycles_s, 32'd0);
      #1;
      i_rst = 1'b0;
      step();
      drive_cmd(PZCOREBUS_READ, 8'd4);
      #1;
      check_eq("t6_old_id_stall", 32'(id_stall_s), 32'd0);
      check_eq("t6_old_id_fwd", 32'(dn_if.mcmd_valid), 32'd1);
      step();
      drop_cmd();
      check_eq("t6_out1", 32'(outstanding_s), 32'd1);
      release_id(8'd5);
      check_eq("t6_stale_unexp", 32'(unexpected_s), 32'd1);
      check_eq("t6_stale_out", 32'(outstanding_s), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
